bram_sdp_fifo: RTL and testbench
================================

BRAM_SDP_FIFO -- requirements
Module: bram_sdp_fifo

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_WIDTH, 18, word width; legal 1..36.
  ADDR_WIDTH, 10, RAM address width; DEPTH = 2**ADDR_WIDTH; legal 9..11.
  AFULL_THRESH, 1020, AFULL_o asserts when LEVEL_o >= value; legal 1..DEPTH.
  AEMPTY_THRESH, 4, AEMPTY_o asserts when LEVEL_o <= value; legal 0..DEPTH-1.
REQ-002 The block SHALL have one clock, clock0; reset RST_N_i is asynchronous and active-low.
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
  clock0  in  1  rising-edge clock for all state and the RAM.
  RST_N_i  in  1  async active-low reset.
  WEN_i  in  1  write request.
  WDATA_i  in  DATA_WIDTH  write data.
  REN_i  in  1  pop request; consumes the word currently on RDATA_o.
  RDATA_o  out  DATA_WIDTH  head word; first-word-fall-through (FWFT); valid when EMPTY_o = 0.
  EMPTY_o  out  1  no valid head word.
  AEMPTY_o  out  1  almost empty.
  FULL_o  out  1  LEVEL_o == DEPTH.
  AFULL_o  out  1  almost full.
  LEVEL_o  out  ADDR_WIDTH+1  stored words, including the head word.
  OVERFLOW_o  out  1  one-cycle pulse: write rejected.
  UNDERFLOW_o  out  1  one-cycle pulse: pop rejected.

Function
REQ-004 Storage SHALL be one inferred simple-dual-port RAM with registered read (mappable to RAM_18K_BLK), plus one FWFT output register.
REQ-005 Write accepted at an edge iff WEN_i=1 and FULL_o=0 before that edge; WDATA_i is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-006 Pop accepted at an edge iff REN_i=1 and EMPTY_o=0; the next word, if any, replaces the head.
REQ-007 FWFT latency: a word written into an empty FIFO SHALL appear on RDATA_o with EMPTY_o=0 exactly 2 edges after its write edge.
REQ-008 Back-to-back pops SHALL sustain one word per cycle while LEVEL_o >= 3; with LEVEL_o 1..2 during refill, EMPTY_o SHALL never show a stale or duplicated word.
REQ-009 LEVEL_o SHALL update on the edge after an accepted operation: write +1, pop -1, both accepted 0; LEVEL_o may be nonzero while EMPTY_o=1 (prefetch in flight).
REQ-010 FULL_o, AFULL_o and AEMPTY_o SHALL be registered and derived from the next LEVEL_o value, so they are coincident with LEVEL_o.
REQ-011 Simultaneous WEN_i and REN_i when full SHALL accept the pop only; the write is rejected and OVERFLOW_o pulses.
REQ-012 Simultaneous WEN_i and REN_i when EMPTY_o=1 SHALL accept the write only; the pop is rejected and UNDERFLOW_o pulses.
REQ-013 Rejected operations SHALL change no pointer, level or data state.
REQ-014 Pointers SHALL wrap from DEPTH-1 to 0 with no data loss or reordering.
REQ-015 RDATA_o SHALL hold its value while EMPTY_o=1 or no pop occurs.
REQ-016 A read from RAM at an address being written in the same cycle SHALL never be issued; the prefetch logic guarantees this.

Reset
REQ-017 While RST_N_i=0, all outputs SHALL asynchronously take their reset values: EMPTY_o=1, AEMPTY_o=1, FULL_o=0, AFULL_o=0, LEVEL_o=0, RDATA_o=0, OVERFLOW_o=0, UNDERFLOW_o=0.
REQ-018 At reset, pointers and the prefetch state SHALL clear; RAM contents are not cleared and SHALL never be visible after reset.
REQ-019 Reset asserted mid-operation SHALL discard all stored words; the first edge after release SHALL accept requests.

Verification
REQ-020 Write 0x00001 at edge k into an empty FIFO -> LEVEL_o=1 after edge k; EMPTY_o=0 and RDATA_o=0x00001 after edge k+2.
REQ-021 Write 1024 words 0..1023, keeping WEN_i high for one extra cycle -> FULL_o=1 and AFULL_o=1 at LEVEL_o=1024, one OVERFLOW_o pulse; then pop all -> data 0..1023 in order, EMPTY_o=1, LEVEL_o=0.
REQ-022 At LEVEL_o=1024, drive WEN_i=REN_i=1 for one cycle -> pop accepted, OVERFLOW_o=1, LEVEL_o=1023; at EMPTY_o=1, drive both -> UNDERFLOW_o=1, LEVEL_o=1.
REQ-023 Streaming: 3000 words with random WEN_i/REN_i (50%) -> scoreboard exact order across pointer wrap; AEMPTY_o iff LEVEL_o<=4 and AFULL_o iff LEVEL_o>=1020 on every cycle.
REQ-024 Pulse RST_N_i low mid-stream with LEVEL_o=37 -> outputs take reset values immediately; a subsequent write of 0x2AAAA is read back first.
REQ-025 DATA_WIDTH=9, ADDR_WIDTH=11 -> 2048-word fill/drain passes, FULL_o asserts at LEVEL_o=2048.

Source files
------------

// File: rtl/bram_sdp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bram_sdp_fifo
// Purpose  : First-word-fall-through FIFO built on one simple-dual-port block
//            RAM with registered read, followed by a single output register.
// Revision : 1.0  initial release
// ============================================================================
module bram_sdp_fifo #(
    parameter int DATA_WIDTH    = 18,
    parameter int ADDR_WIDTH    = 10,
    parameter int AFULL_THRESH  = 1020,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  clock0,
    input  logic                  RST_N_i,
    input  logic                  WEN_i,
    input  logic [DATA_WIDTH-1:0] WDATA_i,
    input  logic                  REN_i,
    output logic [DATA_WIDTH-1:0] RDATA_o,
    output logic                  EMPTY_o,
    output logic                  AEMPTY_o,
    output logic                  FULL_o,
    output logic                  AFULL_o,
    output logic [ADDR_WIDTH:0]   LEVEL_o,
    output logic                  OVERFLOW_o,
    output logic                  UNDERFLOW_o
);

    localparam int                  c_words  = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_depth  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] c_one    = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] c_afull  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] c_aempty = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [c_words];
    logic [DATA_WIDTH-1:0] r_ram_q;
    logic [DATA_WIDTH-1:0] r_dout;
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_level;
    logic                  r_ram_vld;
    logic                  r_out_vld;
    logic                  r_full;
    logic                  r_afull;
    logic                  r_aempty;
    logic                  r_ovf;
    logic                  r_udf;

    logic                  w_wr_acc;
    logic                  w_pop;
    logic                  w_out_load;
    logic                  w_ram_rd;
    logic [ADDR_WIDTH:0]   w_level_nxt;

    assign w_wr_acc   = WEN_i & ~r_full;
    assign w_pop      = REN_i & r_out_vld;
    assign w_out_load = r_ram_vld & (~r_out_vld | w_pop);
    // Pointers carry an extra wrap bit, so inequality means at least one word
    // already sits in RAM; that slot can never be the one written this cycle.
    assign w_ram_rd   = (r_wr_ptr != r_rd_ptr) & (~r_ram_vld | w_out_load);

    always_comb begin
        w_level_nxt = r_level;
        if (w_wr_acc && !w_pop) begin
            w_level_nxt = r_level + c_one;
        end else if (!w_wr_acc && w_pop) begin
            w_level_nxt = r_level - c_one;
        end
    end

    // RAM array and its registered read port are left unreset to map onto a block RAM.
    always_ff @(posedge clock0) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= WDATA_i;
        end
        if (w_ram_rd) begin
            r_ram_q <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
        end
    end

    always_ff @(posedge clock0 or negedge RST_N_i) begin
        if (!RST_N_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_ram_vld <= 1'b0;
            r_out_vld <= 1'b0;
            r_dout    <= '0;
            r_level   <= '0;
            r_full    <= 1'b0;
            r_afull   <= 1'b0;
            r_aempty  <= 1'b1;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_one;
            end
            if (w_ram_rd) begin
                r_rd_ptr <= r_rd_ptr + c_one;
            end
            r_ram_vld <= w_ram_rd | (r_ram_vld & ~w_out_load);
            r_out_vld <= w_out_load | (r_out_vld & ~w_pop);
            if (w_out_load) begin
                r_dout <= r_ram_q;
            end
            r_level  <= w_level_nxt;
            r_full   <= (w_level_nxt == c_depth);
            r_afull  <= (w_level_nxt >= c_afull);
            r_aempty <= (w_level_nxt <= c_aempty);
            r_ovf    <= WEN_i & r_full;
            r_udf    <= REN_i & ~r_out_vld;
        end
    end

    assign RDATA_o     = r_dout;
    assign EMPTY_o     = ~r_out_vld;
    assign AEMPTY_o    = r_aempty;
    assign FULL_o      = r_full;
    assign AFULL_o     = r_afull;
    assign LEVEL_o     = r_level;
    assign OVERFLOW_o  = r_ovf;
    assign UNDERFLOW_o = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_bram_sdp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_sdp_fifo
// Purpose  : Scoreboard bench for bram_sdp_fifo (default and 9x2048 builds).
// Revision : 1.0  initial release
// ============================================================================
module tb_bram_sdp_fifo;

    localparam int c_depth  = 1024;
    localparam int c_afull  = 1020;
    localparam int c_aempty = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        r_rst_n = 1'b0;
    logic        r_wen   = 1'b0;
    logic        r_ren   = 1'b0;
    logic [17:0] r_wdata = '0;
    logic [17:0] w_rdata;
    logic        w_empty, w_aempty, w_full, w_afull, w_ovf, w_udf;
    logic [10:0] w_level;

    logic        r_b_wen   = 1'b0;
    logic        r_b_ren   = 1'b0;
    logic [8:0]  r_b_wdata = '0;
    logic [8:0]  w_b_rdata;
    logic        w_b_empty, w_b_aempty, w_b_full, w_b_afull, w_b_ovf, w_b_udf;
    logic [11:0] w_b_level;

    logic [17:0] exp_q[$];
    int          m_level   = 0;
    logic        m_ovf     = 1'b0;
    logic        m_udf     = 1'b0;
    int          n_checks  = 0;
    int          n_errors  = 0;

    bram_sdp_fifo u_dut (
        .clock0      (clk),
        .RST_N_i     (r_rst_n),
        .WEN_i       (r_wen),
        .WDATA_i     (r_wdata),
        .REN_i       (r_ren),
        .RDATA_o     (w_rdata),
        .EMPTY_o     (w_empty),
        .AEMPTY_o    (w_aempty),
        .FULL_o      (w_full),
        .AFULL_o     (w_afull),
        .LEVEL_o     (w_level),
        .OVERFLOW_o  (w_ovf),
        .UNDERFLOW_o (w_udf)
    );

    bram_sdp_fifo #(
        .DATA_WIDTH   (9),
        .ADDR_WIDTH   (11),
        .AFULL_THRESH (2040),
        .AEMPTY_THRESH(4)
    ) u_dut_b (
        .clock0      (clk),
        .RST_N_i     (r_rst_n),
        .WEN_i       (r_b_wen),
        .WDATA_i     (r_b_wdata),
        .REN_i       (r_b_ren),
        .RDATA_o     (w_b_rdata),
        .EMPTY_o     (w_b_empty),
        .AEMPTY_o    (w_b_aempty),
        .FULL_o      (w_b_full),
        .AFULL_o     (w_b_afull),
        .LEVEL_o     (w_b_level),
        .OVERFLOW_o  (w_b_ovf),
        .UNDERFLOW_o (w_b_udf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: checks status against the level model every cycle and pops the
    // scoreboard whenever a pop is accepted on the coming edge.
    always @(negedge clk) begin
        logic acc_w;
        logic acc_r;
        if (!r_rst_n) begin
            exp_q.delete();
            m_level = 0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
        end else begin
            chk("level",     w_level,  m_level);
            chk("full",      w_full,   m_level == c_depth);
            chk("afull",     w_afull,  m_level >= c_afull);
            chk("aempty",    w_aempty, m_level <= c_aempty);
            chk("overflow",  w_ovf,    m_ovf);
            chk("underflow", w_udf,    m_udf);
            if (!w_empty) begin
                chk("head_present", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) chk("head_data", w_rdata, exp_q[0]);
            end
            acc_w = r_wen && (m_level < c_depth);
            acc_r = r_ren && !w_empty;
            m_ovf = r_wen && (m_level == c_depth);
            m_udf = r_ren && w_empty;
            if (acc_r && exp_q.size() > 0) void'(exp_q.pop_front());
            m_level = m_level + (acc_w ? 1 : 0) - (acc_r ? 1 : 0);
        end
    end

    // One clock of stimulus; the word is scoreboarded when it will be accepted.
    task automatic cyc(input logic wen, input logic [17:0] d, input logic ren);
        r_wen   = wen;
        r_wdata = d;
        r_ren   = ren;
        if (wen && (m_level < c_depth)) exp_q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, '0, 1'b0);
    endtask

    task automatic drain(input int budget, output int used);
        used = 0;
        while (m_level != 0 && used < budget) begin
            cyc(1'b0, '0, 1'b1);
            used++;
        end
        chk("drain_done_level", m_level, 0);
        idle(1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_empty"},  w_empty,  1'b1);
        chk({tag, "_aempty"}, w_aempty, 1'b1);
        chk({tag, "_full"},   w_full,   1'b0);
        chk({tag, "_afull"},  w_afull,  1'b0);
        chk({tag, "_level"},  w_level,  0);
        chk({tag, "_rdata"},  w_rdata,  0);
        chk({tag, "_ovf"},    w_ovf,    1'b0);
        chk({tag, "_udf"},    w_udf,    1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int used;
        int nw;
        int nc;
        int nb;
        int k;
        logic [8:0] exp_b;

        repeat (2) @(posedge clk);
        #1;
        chk_reset("por");
        r_rst_n = 1'b1;

        // Single write into empty FIFO: level after 1 edge, head after 2 edges.
        cyc(1'b1, 18'h00001, 1'b0);
        chk("fwft_level_k",  w_level, 1);
        chk("fwft_empty_k",  w_empty, 1'b1);
        idle(1);
        chk("fwft_empty_k1", w_empty, 1'b1);
        idle(1);
        chk("fwft_empty_k2", w_empty, 1'b0);
        chk("fwft_rdata_k2", w_rdata, 18'h00001);
        cyc(1'b0, '0, 1'b1);
        idle(1);
        chk("fwft_drained",  w_empty, 1'b1);
        chk("fwft_hold",     w_rdata, 18'h00001);

        // Fill to full, then one rejected write.
        for (int i = 0; i < 1024; i++) cyc(1'b1, 18'(i), 1'b0);
        chk("fill_level", w_level, 1024);
        chk("fill_full",  w_full,  1'b1);
        chk("fill_afull", w_afull, 1'b1);
        cyc(1'b1, 18'h3FFFF, 1'b0);
        chk("fill_ovf",       w_ovf,   1'b1);
        chk("fill_ovf_level", w_level, 1024);

        // Simultaneous write and pop while full: pop only.
        cyc(1'b1, 18'h12345, 1'b1);
        chk("full_both_ovf",   w_ovf,   1'b1);
        chk("full_both_level", w_level, 1023);
        chk("full_both_full",  w_full,  1'b0);
        drain(3000, used);
        chk("drain_cycles", used, 1023);
        chk("drain_empty",  w_empty, 1'b1);
        chk("drain_sb",     exp_q.size(), 0);

        // Simultaneous write and pop while empty: write only.
        cyc(1'b1, 18'h00155, 1'b1);
        chk("empty_both_udf",   w_udf,   1'b1);
        chk("empty_both_level", w_level, 1);
        idle(2);
        chk("empty_both_rdata", w_rdata, 18'h00155);
        drain(10, used);

        // Random streaming across pointer wrap.
        nw = 0;
        nc = 0;
        while (nw < 3000 && nc < 20000) begin
            logic w;
            logic r;
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            cyc(w, 18'($urandom), r);
            if (w) nw++;
            nc++;
        end
        chk("stream_writes", nw, 3000);
        drain(200, used);
        chk("stream_sb", exp_q.size(), 0);

        // Reset mid-stream at level 37 with a prefetch in flight.
        for (int i = 0; i < 37; i++) cyc(1'b1, 18'(i + 100), 1'b0);
        r_wen = 1'b0;
        chk("pre_rst_level", w_level, 37);
        r_rst_n = 1'b0;
        #1;
        chk_reset("mid");
        @(posedge clk);
        #1;
        r_rst_n = 1'b1;
        cyc(1'b1, 18'h2AAAA, 1'b0);
        idle(2);
        chk("post_rst_empty", w_empty, 1'b0);
        chk("post_rst_rdata", w_rdata, 18'h2AAAA);
        drain(10, used);

        // 9-bit x 2048 build: fill, full at 2048, drain in order.
        for (int i = 0; i < 2048; i++) begin
            r_b_wen   = 1'b1;
            r_b_wdata = 9'(i);
            @(posedge clk);
            #1;
            if (i == 2046) chk("b_full_at_2047", w_b_full, 1'b0);
        end
        r_b_wen = 1'b0;
        chk("b_level_full", w_b_level, 2048);
        chk("b_full",       w_b_full,  1'b1);
        r_b_ren = 1'b1;
        nb      = 0;
        k       = 0;
        exp_b   = '0;
        while (nb < 2048 && k < 5000) begin
            if (!w_b_empty) begin
                chk("b_data", w_b_rdata, exp_b);
                exp_b = exp_b + 9'd1;
                nb++;
            end
            @(posedge clk);
            #1;
            k++;
        end
        r_b_ren = 1'b0;
        chk("b_drain_count", nb, 2048);
        @(posedge clk);
        #1;
        chk("b_empty", w_b_empty, 1'b1);
        chk("b_level", w_b_level, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
